// File: rtl/usb_tx_sequencer.sv
// USB TX transaction sequencer: PID selection, DATA0/DATA1 toggle, payload pops and status.
// Optional encoder-stall watchdog enabled by defining USB_TX_TIMEOUT_EN.
module usb_tx_sequencer #(
  parameter int MAX_PAYLOAD    = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [1:0] tx_packet,
  input  logic [7:0] buffer_occupancy,
  input  logic       toggle_clr,
  input  logic       enc_ready,
  input  logic       enc_byte_req,
  input  logic       enc_done,
  output logic       enc_start,
  output logic [3:0] enc_pid,
  output logic       enc_last,
  output logic       get_tx_packet_data,
  output logic       tx_transfer_active,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [2:0] {IDLE, START, SEND, WAIT_EOP, ERROR} state_t;

  localparam logic [1:0] CMD_ACK   = 2'd1;
  localparam logic [1:0] CMD_NAK   = 2'd2;
  localparam logic [1:0] CMD_DATA  = 2'd3;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [7:0] MAX_LEN   = 8'(MAX_PAYLOAD);

  state_t     state;
  logic [1:0] cmd;
  logic [7:0] remaining;
  logic       toggle;
  logic       done_reg;
  logic       is_data;
  logic       timeout_hit;
  logic [3:0] pid_sel;

  assign is_data = (cmd == CMD_DATA);

  // A clear arriving with the launch already selects DATA0 for this packet.
  always_comb begin
    pid_sel = 4'b0000;
    case (tx_packet)
      CMD_ACK:  pid_sel = PID_ACK;
      CMD_NAK:  pid_sel = PID_NAK;
      CMD_DATA: pid_sel = (toggle && !toggle_clr) ? PID_DATA1 : PID_DATA0;
      default:  pid_sel = 4'b0000;
    endcase
  end

`ifdef USB_TX_TIMEOUT_EN
  logic [7:0] wdog;
  logic       progress;

  assign progress    = enc_byte_req | enc_done | ((state == START) & enc_ready);
  assign timeout_hit = tx_transfer_active & ~progress & (wdog == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                            wdog <= 8'd0;
    else if (!tx_transfer_active || progress) wdog <= 8'd0;
    else                                   wdog <= wdog + 8'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cmd       <= 2'd0;
      remaining <= 8'd0;
      toggle    <= 1'b0;
      enc_pid   <= 4'b0000;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (timeout_hit) begin
        state <= ERROR;
      end else begin
        case (state)
          IDLE: begin
            if (tx_start && tx_packet != 2'd0) begin
              cmd <= tx_packet;
              if (tx_packet == CMD_DATA && buffer_occupancy > MAX_LEN) begin
                state <= ERROR;
              end else begin
                remaining <= (tx_packet == CMD_DATA) ? buffer_occupancy : 8'd0;
                enc_pid   <= pid_sel;
                state     <= START;
              end
            end
          end
          START: begin
            if (enc_ready) state <= (is_data && remaining != 8'd0) ? SEND : WAIT_EOP;
          end
          SEND: begin
            if (enc_byte_req && remaining != 8'd0) begin
              remaining <= remaining - 8'd1;
              if (remaining == 8'd1) state <= WAIT_EOP;
            end
          end
          WAIT_EOP: begin
            if (enc_done) begin
              done_reg <= 1'b1;
              if (is_data) toggle <= ~toggle;
              state <= IDLE;
            end
          end
          ERROR:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
      // Clear overrides a coincident completion flip.
      if (toggle_clr) toggle <= 1'b0;
      if (toggle_clr && state == START && is_data) enc_pid <= PID_DATA0;
    end
  end

  assign tx_transfer_active = (state == START) || (state == SEND) || (state == WAIT_EOP);
  assign enc_start          = (state == START) && enc_ready;
  assign get_tx_packet_data = (state == SEND) && enc_byte_req && (remaining != 8'd0);
  assign tx_done            = done_reg;
  assign tx_error           = (state == ERROR);

  always_comb begin
    enc_last = 1'b0;
    case (state)
      SEND:     enc_last = (remaining == 8'd1);
      WAIT_EOP: enc_last = is_data;
      default:  enc_last = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Randomized scoreboard bench for usb_tx_sequencer: the driver plays the encoder,
// a monitor pops expected start/pop/done/error events as the DUT emits them.
`timescale 1ns/1ps
module tb_usb_tx_sequencer;
  localparam int MAXP = 64;
  localparam int TOUT = 16;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic [1:0] tx_packet;
  logic [7:0] buffer_occupancy;
  logic       toggle_clr;
  logic       enc_ready;
  logic       enc_byte_req;
  logic       enc_done;
  logic       enc_start;
  logic [3:0] enc_pid;
  logic       enc_last;
  logic       get_tx_packet_data;
  logic       tx_transfer_active;
  logic       tx_done;
  logic       tx_error;

  always #5 clk = ~clk;

  usb_tx_sequencer #(.MAX_PAYLOAD(MAXP), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_packet(tx_packet),
    .buffer_occupancy(buffer_occupancy), .toggle_clr(toggle_clr),
    .enc_ready(enc_ready), .enc_byte_req(enc_byte_req), .enc_done(enc_done),
    .enc_start(enc_start), .enc_pid(enc_pid), .enc_last(enc_last),
    .get_tx_packet_data(get_tx_packet_data), .tx_transfer_active(tx_transfer_active),
    .tx_done(tx_done), .tx_error(tx_error)
  );

  typedef enum logic [1:0] {EV_START, EV_POP, EV_DONE, EV_ERR} ev_kind_t;
  typedef struct packed {
    ev_kind_t   kind;
    logic [3:0] pid;
    logic       last;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic model_toggle = 1'b0;

  function automatic ev_t mk(input ev_kind_t k, input logic [3:0] p, input logic l);
    ev_t e;
    e.kind = k;
    e.pid  = p;
    e.last = l;
    return e;
  endfunction

  function automatic logic [3:0] exp_pid(input logic [1:0] c);
    if (c == 2'd1) return 4'b0010;
    if (c == 2'd2) return 4'b1010;
    return model_toggle ? 4'b1011 : 4'b0011;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic sb_pop(input ev_kind_t k, input logic [3:0] p, input logic l);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_unexpected: got kind=%0d pid=%b last=%b, required no event", k, p, l);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.pid !== p || e.last !== l) begin
        n_fail++;
        $display("FAIL sb_event: got kind=%0d pid=%b last=%b, required kind=%0d pid=%b last=%b",
                 k, p, l, e.kind, e.pid, e.last);
      end
    end
  endtask

  // Monitor: every DUT-issued event must match the head of the expected queue.
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      if (enc_start)          sb_pop(EV_START, enc_pid, 1'b0);
      if (get_tx_packet_data) sb_pop(EV_POP, 4'b0000, enc_last);
      if (tx_done)            sb_pop(EV_DONE, 4'b0000, 1'b0);
      if (tx_error)           sb_pop(EV_ERR, 4'b0000, 1'b0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [1:0] c, input logic [7:0] occ, input bit start_in_send,
                         input bit clr_at_done, input bit extra_req);
    bit err;
    int nb;
    err = (c == 2'd3) && (int'(occ) > MAXP);
    nb  = (c == 2'd3) ? int'(occ) : 0;
    if (err) begin
      exp_q.push_back(mk(EV_ERR, 4'b0000, 1'b0));
    end else begin
      exp_q.push_back(mk(EV_START, exp_pid(c), 1'b0));
      for (int i = 0; i < nb; i++) exp_q.push_back(mk(EV_POP, 4'b0000, i == nb - 1));
      exp_q.push_back(mk(EV_DONE, 4'b0000, 1'b0));
    end
    tick(); tx_start = 1'b1; tx_packet = c; buffer_occupancy = occ;
    tick(); tx_start = 1'b0; tx_packet = 2'($urandom); buffer_occupancy = 8'($urandom);
    enc_ready = err;
    @(negedge clk);
    chk("active_after_start", tx_transfer_active, !err);
    if (err) begin
      chk("error_pulse", tx_error, 1);
      chk("no_enc_start_on_error", enc_start, 0);
      tick(); enc_ready = 1'b0;
      @(negedge clk);
      chk("error_one_cycle", tx_error, 0);
      $display("txn cmd=%0d occ=%0d rejected", c, occ);
      return;
    end
    repeat ($urandom_range(0, 3)) tick();
    tick(); enc_ready = 1'b1;
    tick(); enc_ready = 1'b0;
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      enc_byte_req = 1'b1;
      if (start_in_send && i == 0) begin
        tx_start = 1'b1; tx_packet = 2'd3; buffer_occupancy = 8'd4;
      end
      tick();
      enc_byte_req = 1'b0; tx_start = 1'b0;
    end
    if (extra_req) begin
      enc_byte_req = 1'b1;
      tick();
      enc_byte_req = 1'b0;
    end
    @(negedge clk);
    chk("enc_last_wait_eop", enc_last, c == 2'd3);
    chk("active_wait_eop", tx_transfer_active, 1);
    tick(); enc_done = 1'b1; toggle_clr = clr_at_done;
    tick(); enc_done = 1'b0; toggle_clr = 1'b0;
    if (clr_at_done) model_toggle = 1'b0;
    else if (c == 2'd3) model_toggle = ~model_toggle;
    @(negedge clk);
    chk("done_pulse", tx_done, 1);
    chk("active_after_done", tx_transfer_active, 0);
    $display("txn cmd=%0d occ=%0d pops=%0d clr=%0d next_toggle=%0d", c, occ, nb, clr_at_done, model_toggle);
  endtask

  task automatic idle_clr();
    tick(); toggle_clr = 1'b1;
    tick(); toggle_clr = 1'b0;
    model_toggle = 1'b0;
  endtask

  task automatic reset_mid_send();
    exp_q.push_back(mk(EV_START, exp_pid(2'd3), 1'b0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(EV_POP, 4'b0000, 1'b0));
    tick(); tx_start = 1'b1; tx_packet = 2'd3; buffer_occupancy = 8'd10;
    tick(); tx_start = 1'b0; enc_ready = 1'b1;
    tick(); enc_ready = 1'b0;
    repeat (3) begin
      enc_byte_req = 1'b1;
      tick();
    end
    enc_ready = 1'b1;
    n_rst = 1'b0;
    #1;
    chk("rst_enc_start", enc_start, 0);
    chk("rst_enc_pid", enc_pid, 0);
    chk("rst_enc_last", enc_last, 0);
    chk("rst_get_data", get_tx_packet_data, 0);
    chk("rst_active", tx_transfer_active, 0);
    chk("rst_done_error", {tx_done, tx_error}, 0);
    enc_byte_req = 1'b0; enc_ready = 1'b0;
    tick(); tick();
    n_rst = 1'b1;
    model_toggle = 1'b0;
    $display("txn reset mid-send after 3 pops");
  endtask

  initial begin
    n_rst = 1'b0; tx_start = 1'b0; tx_packet = 2'd0; buffer_occupancy = 8'd0;
    toggle_clr = 1'b0; enc_ready = 1'b0; enc_byte_req = 1'b0; enc_done = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {enc_start, enc_pid, enc_last, get_tx_packet_data,
                          tx_transfer_active, tx_done, tx_error}, 0);
    tick(); n_rst = 1'b1;
    @(negedge clk);
    chk("post_reset_active", tx_transfer_active, 0);
    chk("post_reset_pid", enc_pid, 0);

    run_txn(2'd3, 8'd4, 0, 0, 0);
    run_txn(2'd3, 8'd4, 0, 0, 0);
    run_txn(2'd1, 8'd9, 0, 0, 1);
    run_txn(2'd3, 8'd65, 0, 0, 0);
    run_txn(2'd3, 8'd0, 0, 0, 1);
    run_txn(2'd3, 8'd5, 1, 1, 1);
    run_txn(2'd3, 8'd3, 0, 0, 0);
    run_txn(2'd2, 8'd0, 0, 0, 0);

    tick(); tx_start = 1'b1; tx_packet = 2'd0; enc_ready = 1'b1;
    tick(); tx_start = 1'b0;
    @(negedge clk);
    chk("none_cmd_active", tx_transfer_active, 0);
    chk("none_cmd_no_start", enc_start, 0);
    enc_ready = 1'b0;

    reset_mid_send();

`ifdef USB_TX_TIMEOUT_EN
    exp_q.push_back(mk(EV_ERR, 4'b0000, 1'b0));
    tick(); tx_start = 1'b1; tx_packet = 2'd3; buffer_occupancy = 8'd2;
    tick(); tx_start = 1'b0;
    for (int i = 0; i < TOUT; i++) begin
      @(negedge clk);
      chk("timeout_not_yet", {tx_error, tx_transfer_active}, 2'b01);
    end
    @(negedge clk);
    chk("timeout_error", {tx_error, tx_transfer_active}, 2'b10);
    $display("txn watchdog timeout in START");
`endif

    for (int t = 0; t < 30; t++) begin
      logic [1:0] c;
      logic [7:0] o;
      int r;
      c = 2'($urandom_range(1, 3));
      r = $urandom_range(0, 5);
      case (r)
        0:       o = 8'd0;
        1:       o = 8'd1;
        2:       o = 8'(MAXP);
        3:       o = 8'(MAXP + 1);
        4:       o = 8'($urandom_range(2, MAXP - 1));
        default: o = 8'($urandom_range(MAXP + 2, 255));
      endcase
      if ($urandom_range(0, 4) == 0) idle_clr();
      run_txn(c, o, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1);
    end

    repeat (4) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
